// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, padder FSM states and byte-lane helper.
// Used by both the padder front end and the compression core.
package sha256_pkg;

    localparam int SHA256_BLK_W = 512;
    localparam int SHA256_LEN_W = 64;
    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        S_FILL,
        S_EMIT,
        S_EMIT_TAIL
    } padder_state_t;

    localparam logic [31:0] SHA256_H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Byte 0 of a block sits in the top byte lane.
    function automatic logic [8:0] sha256_byte_msb(input logic [5:0] i);
        return 9'd511 - {i, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: byte stream in, 512-bit blocks out with first/last flags.
// Define SHA256_PADDER_BLKCNT_EN to add the blk_count port (blocks emitted since reset).
module sha256_padder
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_keep,
    input  logic        in_last,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic [511:0] blk_data,
    output logic        blk_first,
    output logic        blk_last
`ifdef SHA256_PADDER_BLKCNT_EN
   ,output logic [31:0] blk_count
`endif
);

    padder_state_t             state;
    logic [SHA256_BLK_W-1:0]   blk_buf;
    logic [5:0]                idx;
    logic [SHA256_LEN_W-1:0]   len;
    logic                      first_pend;
    logic                      tail_pend;
    logic                      marker_pend;

    logic [5:0]                mark;
    logic [SHA256_LEN_W-1:0]   len_n;
    logic                      wrap;

    assign blk_data = blk_buf;

    always_comb begin
        len_n = len + (in_keep ? 64'd8 : 64'd0);
        mark  = in_keep ? idx + 6'd1 : idx;
        // Final byte filled lane 63: the marker spills into the tail block.
        wrap  = in_keep && (idx == 6'd63);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FILL;
            blk_buf     <= '0;
            idx         <= '0;
            len         <= '0;
            first_pend  <= 1'b1;
            tail_pend   <= 1'b0;
            marker_pend <= 1'b0;
            in_ready    <= 1'b0;
            blk_valid   <= 1'b0;
            blk_first   <= 1'b0;
            blk_last    <= 1'b0;
`ifdef SHA256_PADDER_BLKCNT_EN
            blk_count   <= '0;
`endif
        end else begin
            case (state)
                S_FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (in_keep) begin
                            blk_buf[sha256_byte_msb(idx) -: 8] <= in_data;
                            idx <= idx + 6'd1;
                            len <= len_n;
                        end
                        if (in_last || wrap) begin
                            state     <= S_EMIT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_first <= first_pend;
                            blk_last  <= 1'b0;
                        end
                        if (in_last) begin
                            if (wrap) begin
                                tail_pend   <= 1'b1;
                                marker_pend <= 1'b1;
                            end else if (mark <= 6'd55) begin
                                blk_buf[sha256_byte_msb(mark) -: 8] <= SHA256_PAD_BYTE;
                                blk_buf[SHA256_LEN_W-1:0]           <= len_n;
                                blk_last                            <= 1'b1;
                            end else begin
                                blk_buf[sha256_byte_msb(mark) -: 8] <= SHA256_PAD_BYTE;
                                tail_pend                           <= 1'b1;
                            end
                        end
                    end
                end

                S_EMIT: begin
                    if (blk_ready) begin
`ifdef SHA256_PADDER_BLKCNT_EN
                        blk_count  <= blk_count + 32'd1;
`endif
                        first_pend <= 1'b0;
                        if (tail_pend) begin
                            blk_buf     <= {(marker_pend ? SHA256_PAD_BYTE : 8'h00),
                                            {(SHA256_BLK_W-8-SHA256_LEN_W){1'b0}}, len};
                            tail_pend   <= 1'b0;
                            marker_pend <= 1'b0;
                            blk_first   <= 1'b0;
                            blk_last    <= 1'b1;
                            state       <= S_EMIT_TAIL;
                        end else begin
                            blk_buf   <= '0;
                            blk_valid <= 1'b0;
                            blk_first <= 1'b0;
                            blk_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= S_FILL;
                            if (blk_last) begin
                                first_pend <= 1'b1;
                                len        <= '0;
                                idx        <= '0;
                            end
                        end
                    end
                end

                S_EMIT_TAIL: begin
                    if (blk_ready) begin
`ifdef SHA256_PADDER_BLKCNT_EN
                        blk_count  <= blk_count + 32'd1;
`endif
                        blk_buf    <= '0;
                        first_pend <= 1'b1;
                        len        <= '0;
                        idx        <= '0;
                        blk_valid  <= 1'b0;
                        blk_last   <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= S_FILL;
                    end
                end

                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder against a queue-based padding model.
// Build with +define+SHA256_PADDER_BLKCNT_EN to also check blk_count.
module tb_sha256_padder;

    typedef logic [7:0]   byte_q_t [$];
    typedef logic [511:0] blk_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_keep, in_last;
    logic [7:0]   in_data;
    logic         blk_valid, blk_ready, blk_first, blk_last;
    logic [511:0] blk_data;
`ifdef SHA256_PADDER_BLKCNT_EN
    logic [31:0]  blk_count;
`endif

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    blk_t exp_d[$];
    bit   exp_f[$], exp_l[$];
    blk_t got_d[$];
    bit   got_f[$], got_l[$];

    sha256_padder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last)
`ifdef SHA256_PADDER_BLKCNT_EN
      , .blk_count(blk_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    function automatic void model_add(input byte_q_t msg);
        byte_q_t     p;
        logic [63:0] bits;
        blk_t        d;
        int          nb;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int j = 0; j < 64; j++) d[511-8*j -: 8] = p[64*b+j];
            exp_d.push_back(d);
            exp_f.push_back(b == 0);
            exp_l.push_back(b == nb - 1);
        end
        exp_cnt += nb;
    endfunction

    function automatic byte_q_t rand_msg(input int n);
        byte_q_t m;
        for (int k = 0; k < n; k++) m.push_back(8'($urandom));
        return m;
    endfunction

    task automatic clear_exp();
        exp_d.delete(); exp_f.delete(); exp_l.delete();
    endtask

    task automatic send_msg(input byte_q_t msg, input bit do_last, input bit gaps);
        int n, beats, i, cyc;
        bit acc;
        n = msg.size();
        beats = (n == 0) ? 1 : n;
        i = 0;
        cyc = 0;
        while (i < beats && cyc < 3000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_keep  = (n != 0);
            in_data  = (n != 0) ? msg[i] : 8'h00;
            in_last  = do_last && (i == beats - 1);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
        checks++;
        if (i < beats) begin
            errors++;
            $display("FAIL send_timeout: accepted %0d beats, required %0d", i, beats);
        end
    endtask

    task automatic collect(input int nblk, input bit rand_ready);
        int cyc;
        cyc = 0;
        got_d.delete(); got_f.delete(); got_l.delete();
        while (got_d.size() < nblk && cyc < 3000) begin
            blk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (blk_valid && blk_ready) begin
                got_d.push_back(blk_data);
                got_f.push_back(blk_first);
                got_l.push_back(blk_last);
            end
            @(posedge clk); #1;
            cyc++;
        end
        blk_ready = 1'b0;
        checks++;
        if (got_d.size() < nblk) begin
            errors++;
            $display("FAIL collect_timeout: got %0d blocks, required %0d", got_d.size(), nblk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
        in_data = 8'h00; blk_ready = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_first !== 1'b0 || blk_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready=%b blk_valid=%b first=%b last=%b, required all 0",
                     in_ready, blk_valid, blk_first, blk_last);
        end
        checks++;
        if (blk_data !== 512'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0", blk_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_cnt = 0;
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: in_ready=%b blk_valid=%b, required 1 and 0", in_ready, blk_valid);
        end
`ifdef SHA256_PADDER_BLKCNT_EN
        checks++;
        if (blk_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", blk_count);
        end
`endif
    endtask

    task automatic test_abc();
        byte_q_t m;
        blk_t    c;
        m = '{8'h61, 8'h62, 8'h63};
        c = {32'h61626380, 448'd0, 32'h00000018};
        clear_exp();
        model_add(m);
        fork
            send_msg(m, 1'b1, 1'b0);
            collect(1, 1'b0);
        join
        checks++;
        if (got_d.size() !== 1 || got_d[0] !== c || got_f[0] !== 1'b1 || got_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL abc: got %0d blocks first %h f=%b l=%b, required 1 block %h f=1 l=1",
                     got_d.size(), got_d[0], got_f[0], got_l[0], c);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL abc_extra: blk_valid=%b after message, required 0", blk_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        byte_q_t m;
        blk_t    c;
        c = {8'h80, 504'd0};
        clear_exp();
        model_add(m);
        fork
            send_msg(m, 1'b1, 1'b0);
            collect(1, 1'b0);
        join
        checks++;
        if (got_d.size() !== 1 || got_d[0] !== c || got_f[0] !== 1'b1 || got_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL empty: got %h f=%b l=%b, required %h f=1 l=1", got_d[0], got_f[0], got_l[0], c);
        end
    endtask

    task automatic test_boundaries();
        int      lens[6];
        byte_q_t m;
        lens = '{55, 56, 64, 63, 119, 128};
        for (int t = 0; t < 6; t++) begin
            m = (t < 3) ? rand_msg(0) : rand_msg(lens[t]);
            if (t < 3) for (int k = 0; k < lens[t]; k++) m.push_back(8'h00);
            clear_exp();
            model_add(m);
            fork
                send_msg(m, 1'b1, 1'b0);
                collect(exp_d.size(), 1'b0);
            join
            checks++;
            if (got_d.size() !== exp_d.size()) begin
                errors++;
                $display("FAIL bound_count len=%0d: got %0d blocks, required %0d", lens[t], got_d.size(), exp_d.size());
            end
            for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
                checks++;
                if (got_d[k] !== exp_d[k] || got_f[k] !== exp_f[k] || got_l[k] !== exp_l[k]) begin
                    errors++;
                    $display("FAIL bound len=%0d blk%0d: got %h f=%b l=%b, required %h f=%b l=%b",
                             lens[t], k, got_d[k], got_f[k], got_l[k], exp_d[k], exp_f[k], exp_l[k]);
                end
            end
            // Hand-derived values for the zero-filled cases.
            checks++;
            if (t == 0 && got_d[0] !== {440'd0, 8'h80, 64'h1B8}) begin
                errors++;
                $display("FAIL len55_const: got %h", got_d[0]);
            end else if (t == 1 && (got_d[0] !== {448'd0, 8'h80, 56'd0} || got_d[1] !== {448'd0, 64'h1C0})) begin
                errors++;
                $display("FAIL len56_const: got %h / %h", got_d[0], got_d[1]);
            end else if (t == 2 && (got_d[0] !== 512'd0 || got_d[1] !== {8'h80, 440'd0, 64'h200})) begin
                errors++;
                $display("FAIL len64_const: got %h / %h", got_d[0], got_d[1]);
            end
        end
    endtask

    task automatic test_random();
        byte_q_t m;
        for (int t = 0; t < 8; t++) begin
            m = rand_msg($urandom_range(0, 150));
            clear_exp();
            model_add(m);
            fork
                send_msg(m, 1'b1, 1'b1);
                collect(exp_d.size(), 1'b1);
            join
            checks++;
            if (got_d.size() !== exp_d.size()) begin
                errors++;
                $display("FAIL rand_count len=%0d: got %0d, required %0d", m.size(), got_d.size(), exp_d.size());
            end
            for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
                checks++;
                if (got_d[k] !== exp_d[k] || got_f[k] !== exp_f[k] || got_l[k] !== exp_l[k]) begin
                    errors++;
                    $display("FAIL rand len=%0d blk%0d: got %h f=%b l=%b, required %h f=%b l=%b",
                             m.size(), k, got_d[k], got_f[k], got_l[k], exp_d[k], exp_f[k], exp_l[k]);
                end
            end
        end
`ifdef SHA256_PADDER_BLKCNT_EN
        checks++;
        if (blk_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL rand_blk_count: got %0d, required %0d", blk_count, exp_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        byte_q_t m0, m1, m2;
        m0 = rand_msg(64);
        m1 = rand_msg(0);
        m2 = rand_msg(57);
        clear_exp();
        model_add(m0); model_add(m1); model_add(m2);
        fork
            begin
                send_msg(m0, 1'b1, 1'b0);
                send_msg(m1, 1'b1, 1'b0);
                send_msg(m2, 1'b1, 1'b0);
            end
            collect(exp_d.size(), 1'b0);
        join
        checks++;
        if (got_d.size() !== exp_d.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d, required %0d", got_d.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_f[k] !== exp_f[k] || got_l[k] !== exp_l[k]) begin
                errors++;
                $display("FAIL b2b blk%0d: got %h f=%b l=%b, required %h f=%b l=%b",
                         k, got_d[k], got_f[k], got_l[k], exp_d[k], exp_f[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        byte_q_t m;
        blk_t    snap;
        bit      sf, sl;
        int      cyc;
        m = rand_msg(120);
        clear_exp();
        model_add(m);
        blk_ready = 1'b0;
        fork
            send_msg(m, 1'b1, 1'b0);
            begin
                cyc = 0;
                while (cyc < 500) begin
                    @(negedge clk);
                    if (blk_valid) break;
                    @(posedge clk); #1;
                    cyc++;
                end
                snap = blk_data; sf = blk_first; sl = blk_last;
                @(posedge clk); #1;
                for (int h = 0; h < 10; h++) begin
                    @(negedge clk);
                    checks++;
                    if (blk_valid !== 1'b1 || in_ready !== 1'b0 || blk_data !== snap ||
                        blk_first !== sf || blk_last !== sl) begin
                        errors++;
                        $display("FAIL bp_hold cyc%0d: valid=%b in_ready=%b first=%b last=%b data %h, required 1 0 %b %b %h",
                                 h, blk_valid, in_ready, blk_first, blk_last, blk_data, sf, sl, snap);
                    end
                    @(posedge clk); #1;
                end
                collect(exp_d.size(), 1'b0);
            end
        join
        checks++;
        if (got_d.size() !== exp_d.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d, required %0d", got_d.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_f[k] !== exp_f[k] || got_l[k] !== exp_l[k]) begin
                errors++;
                $display("FAIL bp blk%0d: got %h f=%b l=%b, required %h f=%b l=%b",
                         k, got_d[k], got_f[k], got_l[k], exp_d[k], exp_f[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t m80, m;
        m80 = rand_msg(80);
        fork
            send_msg(m80, 1'b0, 1'b0);
            collect(1, 1'b0);
        join
        #3 reset = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_data !== 512'd0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b blk_valid=%b data %h, required 0 0 0", in_ready, blk_valid, blk_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_cnt = 0;
`ifdef SHA256_PADDER_BLKCNT_EN
        checks++;
        if (blk_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d, required 0", blk_count);
        end
`endif
        m = rand_msg(10);
        clear_exp();
        model_add(m);
        fork
            send_msg(m, 1'b1, 1'b1);
            collect(1, 1'b0);
        join
        checks++;
        if (got_d[0] !== exp_d[0] || got_f[0] !== 1'b1 || got_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: got %h f=%b l=%b, required %h f=1 l=1", got_d[0], got_f[0], got_l[0], exp_d[0]);
        end
`ifdef SHA256_PADDER_BLKCNT_EN
        checks++;
        if (blk_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL after_reset_count: got %0d, required %0d", blk_count, exp_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
